// File: rtl/ci_media_tx.sv
// Host-to-CAM transport-stream transmitter: ingests a byte stream, keeps only sync-aligned complete
// TS packets in a byte FIFO, and replays each one as a contiguous burst on a divided media clock.
module ci_media_tx #(
  parameter int          FIFO_DEPTH = 512,
  parameter int          CLK_DIV    = 4,
  parameter int          PKT_LEN    = 188,
  parameter logic [7:0]  SYNC_BYTE  = 8'h47
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  input  logic                          s_sop,
  output logic                          s_ready,
  input  logic                          enable,
  output logic [7:0]                    ci_mdo,
  output logic                          ci_mclko,
  output logic                          ci_moval,
  output logic                          ci_mostrt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pkt_count,
  output logic                          sync_err
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int IW  = $clog2(PKT_LEN);
  localparam int TW  = $clog2(PKT_LEN + 1);
  localparam int PHW = $clog2(CLK_DIV);

  localparam logic [AW:0]    DEPTH_L  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]    PKT_L    = PKT_LEN[AW:0];
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(PKT_LEN - 1);
  localparam logic [TW-1:0]  TX_ONE   = TW'(1);
  localparam logic [TW-1:0]  TX_END   = TW'(PKT_LEN);
  localparam logic [TW-1:0]  TX_LAST  = TW'(PKT_LEN - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(CLK_DIV - 1);
  localparam logic [PHW-1:0] PH_HALF  = PHW'(CLK_DIV / 2);

  typedef enum logic {ING_HUNT, ING_LOCK} ing_state_t;
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [7:0]    rd_data;
  logic [AW:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [AW:0]   level, avail, avail_reg;
  logic          accept, is_sync, wr_en;
  logic [AW:0]   wr_addr;
  ing_state_t    ing_state;
  logic [IW-1:0] idx;
  tx_state_t     tx_state;
  logic [TW-1:0] tx_idx;
  logic [PHW-1:0] phase, phase_next;
  logic          tick, start;

  assign level      = wr_ptr - rd_ptr;
  assign avail      = commit_ptr - rd_ptr;
  assign s_ready    = level < DEPTH_L;
  assign fifo_level = level;
  assign accept     = s_valid && s_ready;
  assign is_sync    = s_sop && (s_data == SYNC_BYTE);

  // A mid-packet sync byte restarts the packet at the commit point, overwriting the partial one.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_ptr;
    if (accept) begin
      if (ing_state == ING_HUNT || idx == '0) begin
        wr_en = is_sync;
      end else if (s_sop) begin
        wr_en   = is_sync;
        wr_addr = commit_ptr;
      end else begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW-1:0]] <= s_data;
    rd_data <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ing_state  <= ING_HUNT;
      idx        <= '0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (accept) begin
        case (ing_state)
          ING_HUNT: begin
            if (is_sync) begin
              wr_ptr    <= wr_ptr + 1'b1;
              idx       <= IDX_ONE;
              ing_state <= ING_LOCK;
            end
          end
          ING_LOCK: begin
            if (idx == '0) begin
              if (is_sync) begin
                wr_ptr <= wr_ptr + 1'b1;
                idx    <= IDX_ONE;
              end else begin
                ing_state <= ING_HUNT;
                sync_err  <= s_sop;
              end
            end else if (s_sop) begin
              sync_err <= 1'b1;
              if (is_sync) begin
                wr_ptr <= commit_ptr + 1'b1;
                idx    <= IDX_ONE;
              end else begin
                wr_ptr    <= commit_ptr;
                idx       <= '0;
                ing_state <= ING_HUNT;
              end
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              if (idx == IDX_LAST) begin
                commit_ptr <= wr_ptr + 1'b1;
                idx        <= '0;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: ing_state <= ING_HUNT;
        endcase
      end
    end
  end

  // Outputs update on the edge where phase wraps to 0, i.e. together with the falling media clock.
  assign tick       = (phase == PH_LAST);
  assign phase_next = tick ? '0 : phase + 1'b1;
  assign start      = tick && enable && (avail_reg >= PKT_L) &&
                      (tx_state == TX_IDLE || tx_idx == TX_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      ci_mclko  <= 1'b0;
      avail_reg <= '0;
      tx_state  <= TX_IDLE;
      tx_idx    <= '0;
      rd_ptr    <= '0;
      ci_mdo    <= '0;
      ci_moval  <= 1'b0;
      ci_mostrt <= 1'b0;
      pkt_count <= '0;
    end else begin
      phase     <= phase_next;
      ci_mclko  <= (phase_next >= PH_HALF);
      avail_reg <= avail;
      if (tick) begin
        if (start) begin
          ci_mdo    <= rd_data;
          ci_moval  <= 1'b1;
          ci_mostrt <= 1'b1;
          rd_ptr    <= rd_ptr + 1'b1;
          tx_idx    <= TX_ONE;
          tx_state  <= TX_SEND;
        end else if (tx_state == TX_SEND && tx_idx != TX_END) begin
          ci_mdo    <= rd_data;
          ci_mostrt <= 1'b0;
          rd_ptr    <= rd_ptr + 1'b1;
          tx_idx    <= tx_idx + 1'b1;
          if (tx_idx == TX_LAST) pkt_count <= pkt_count + 1'b1;
        end else begin
          ci_mdo    <= '0;
          ci_moval  <= 1'b0;
          ci_mostrt <= 1'b0;
          tx_idx    <= '0;
          tx_state  <= TX_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ci_media_tx.sv
// Randomized bench for ci_media_tx: a queue-based packet model predicts which bytes reach the CAM pins.
module tb_ci_media_tx;

  localparam int PKT   = 188;
  localparam int DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_sop, enable;
  logic [7:0]  s_data;
  logic        s_ready, ci_mclko, ci_moval, ci_mostrt, sync_err;
  logic [7:0]  ci_mdo;
  logic [9:0]  fifo_level;
  logic [15:0] pkt_count;

  ci_media_tx dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_sop(s_sop),
    .s_ready(s_ready), .enable(enable), .ci_mdo(ci_mdo), .ci_mclko(ci_mclko),
    .ci_moval(ci_moval), .ci_mostrt(ci_mostrt), .fifo_level(fifo_level),
    .pkt_count(pkt_count), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pin monitor: captures bytes at rising media clock and measures moval run lengths.
  logic [8:0] rx_q[$];
  int  run = 0, last_run = 0;
  logic mclk_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      mclk_prev = 1'b0;
    end else begin
      if (ci_moval) run++;
      else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (ci_mclko && !mclk_prev && ci_moval) rx_q.push_back({ci_mostrt, ci_mdo});
      mclk_prev = ci_mclko;
    end
  end

  // Packet model: committed packets in exp_q, the packet being assembled in cur.
  logic [7:0] exp_q[$];
  logic [7:0] cur[$];
  int  exp_rd = 0, rx_rd = 0, exp_pkts = 0, accepted = 0;
  bit  m_lock = 0;

  function automatic logic model_accept(input logic [7:0] d, input logic sop);
    logic good, err;
    good = sop && (d == 8'h47);
    err  = 1'b0;
    if (!m_lock) begin
      if (good) begin cur.delete(); cur.push_back(d); m_lock = 1; end
    end else if (cur.size() == 0) begin
      if (good) cur.push_back(d);
      else begin m_lock = 0; err = sop; end
    end else if (sop) begin
      err = 1'b1;
      cur.delete();
      if (good) cur.push_back(d);
      else m_lock = 0;
    end else begin
      cur.push_back(d);
      if (cur.size() == PKT) begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
        cur.delete();
        exp_pkts++;
      end
    end
    return err;
  endfunction

  task automatic compare_rx();
    logic [8:0] r;
    while (rx_rd < rx_q.size()) begin
      r = rx_q[rx_rd];
      rx_rd++;
      chk("byte_expected", exp_rd < exp_q.size(), 1);
      if (exp_rd < exp_q.size()) begin
        chk("mdo", r[7:0], exp_q[exp_rd]);
        chk("mostrt", r[8], (exp_rd % PKT) == 0);
        exp_rd++;
      end
    end
  endtask

  task automatic push(input logic [7:0] d, input logic sop);
    int n;
    logic e;
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_sop = sop;
    n = 0;
    while (!s_ready && n < 5000) begin
      @(negedge clk);
      compare_rx();
      n++;
    end
    if (!s_ready) begin
      chk("ready_timeout", s_ready, 1);
    end else begin
      @(posedge clk);
      e = model_accept(d, sop);
      accepted++;
      #1;
      chk("sync_err", sync_err, e);
    end
    s_valid = 1'b0; s_sop = 1'b0;
  endtask

  task automatic push_pkt();
    push(8'h47, 1'b1);
    for (int i = 1; i < PKT; i++) push(8'($urandom_range(0, 255)), 1'b0);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    compare_rx();
    while (!(exp_rd == exp_q.size() && !ci_moval) && n < limit) begin
      @(negedge clk);
      compare_rx();
      n++;
    end
    chk("drain_done", exp_rd, exp_q.size());
    repeat (2) @(negedge clk);
    compare_rx();
  endtask

  task automatic wait_rd(input int target);
    int n;
    n = 0;
    while (exp_rd < target && n < 4000) begin
      @(negedge clk);
      compare_rx();
      n++;
    end
    chk("reach_byte", exp_rd >= target, 1);
  endtask

  int start_a, j, len, mode, n;
  logic [7:0] d;
  logic sop;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_data = '0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_moval", ci_moval, 0);
    chk("rst_mostrt", ci_mostrt, 0);
    chk("rst_mdo", ci_mdo, 0);
    chk("rst_mclko", ci_mclko, 0);
    chk("rst_ready", s_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_count", pkt_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single packet 0x47,0x01..0xBB
    enable = 1'b1;
    push(8'h47, 1'b1);
    for (int i = 1; i < PKT; i++) push(8'(i), 1'b0);
    wait_drain(3000);
    chk("single_run", last_run, 752);
    chk("single_count", pkt_count, 1);
    chk("single_level", fifo_level, 0);
    chk("idle_mdo", ci_mdo, 0);

    // Two packets back-to-back
    push_pkt();
    push_pkt();
    wait_drain(4000);
    chk("b2b_run", last_run, 1504);
    chk("b2b_count", pkt_count, exp_pkts);

    // Bad sync byte, then a packet restarted by a sync byte at index 100
    push(8'h00, 1'b1);
    for (int i = 1; i < PKT; i++) push(8'($urandom_range(0, 255)), 1'b0);
    push(8'h47, 1'b1);
    for (int i = 1; i < 100; i++) push(8'($urandom_range(0, 255)), 1'b0);
    chk("partial_level", fifo_level, cur.size());
    push(8'h47, 1'b1);
    chk("restart_level", fifo_level, cur.size());
    for (int i = 1; i < PKT; i++) push(8'($urandom_range(0, 255)), 1'b0);
    wait_drain(3000);
    chk("restart_count", pkt_count, exp_pkts);

    // Fill to full with enable low, then drain
    @(negedge clk);
    enable = 1'b0;
    n = accepted;
    fork
      begin
        for (int p = 0; p < 3; p++) push_pkt();
      end
      begin
        int w;
        w = 0;
        while (fifo_level != 10'(DEPTH) && w < 3000) begin @(negedge clk); w++; end
        chk("full_level", fifo_level, DEPTH);
        chk("full_ready", s_ready, 0);
        chk("full_accepted", accepted - n, DEPTH);
        repeat (20) @(negedge clk);
        chk("full_stall", s_ready, 0);
        chk("full_no_tx", ci_moval, 0);
        enable = 1'b1;
      end
    join
    wait_drain(6000);
    chk("fill_count", pkt_count, exp_pkts);
    chk("fill_level", fifo_level, 0);

    // Enable dropped mid-packet, then reset mid-packet
    start_a = exp_q.size();
    push_pkt();
    push_pkt();
    wait_rd(start_a + 50);
    @(negedge clk);
    enable = 1'b0;
    wait_rd(start_a + PKT);
    repeat (1200) begin @(negedge clk); compare_rx(); end
    chk("hold_rd", exp_rd, start_a + PKT);
    chk("hold_moval", ci_moval, 0);
    chk("hold_level", fifo_level, PKT);
    chk("hold_count", pkt_count, exp_pkts - 1);
    enable = 1'b1;
    wait_rd(start_a + PKT + 90);
    @(negedge clk);
    rst = 1'b1;
    #1;
    compare_rx();
    m_lock = 0; cur.delete(); exp_rd = exp_q.size(); exp_pkts = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_moval", ci_moval, 0);
    chk("rst_mid_level", fifo_level, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare_rx();
    chk("rst_mid_count", pkt_count, 0);

    // Randomized packet stream with sync faults and enable changes
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      enable = (fifo_level > 10'd136) ? 1'b1 : (($urandom % 4) != 0);
      mode = $urandom % 6;
      j = $urandom_range(1, PKT - 2);
      len = (mode == 2) ? PKT + j : PKT;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom_range(0, 255));
        sop = 1'b0;
        if (i == 0) begin
          sop = (mode != 1);
          d = (mode == 0) ? 8'($urandom_range(0, 70)) : 8'h47;
        end else if (i == j && mode == 2) begin
          sop = 1'b1; d = 8'h47;
        end else if (i == j && mode == 3) begin
          sop = 1'b1; d = 8'($urandom_range(0, 70));
        end
        if ($urandom % 8 == 0) repeat ($urandom % 3) @(negedge clk);
        push(d, sop);
      end
    end
    @(negedge clk);
    enable = 1'b1;
    wait_drain(20000);
    chk("rand_count", pkt_count, exp_pkts);
    chk("rand_level", fifo_level, cur.size());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
